// File: rtl/sd_spi_pkg.sv
// Shared encodings and 50 MHz divider defaults for the SD-card SPI master.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        CMD_XFER   = 2'b00,
        CMD_CS_ON  = 2'b01,
        CMD_CS_OFF = 2'b10,
        CMD_INIT   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_e;

    // Half-period minus one: 63 clocks -> ~397 kHz, 2 clocks -> 12.5 MHz.
    localparam int DIV_SLOW_50M = 62;
    localparam int DIV_FAST_50M = 1;

endpackage

// File: rtl/sd_spi_div.sv
// Half-period counter: pulses tick once every div+1 cycles while enabled.
module sd_spi_div #(
    parameter int DIVW = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    output logic            tick
);

    logic [DIVW-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + DIVW'(1);
    end

endmodule

// File: rtl/sd_spi_master.sv
// SPI-mode byte engine for the SD slot: XFER / CS_ON / CS_OFF / INIT commands,
// mode 0, MSB first, with slow/fast clock selected per command.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int DIV_SLOW   = DIV_SLOW_50M,
    parameter int DIV_FAST   = DIV_FAST_50M,
    parameter int DIVW       = 8,
    parameter int INIT_BYTES = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] cmd,
    input  logic       fast,
    input  logic [7:0] din,
    input  logic       valid,
    output logic       ready,
    output logic       done,
    output logic [7:0] dout,
    output logic       sd_clk,
    output logic       sd_mosi,
    output logic       sd_cs,
    input  logic       sd_miso
);

    localparam int BCW = (INIT_BYTES > 1) ? $clog2(INIT_BYTES) : 1;

    state_e          state, state_n;
    cmd_e            cmd_r;
    logic            fast_r;
    logic [7:0]      shreg;
    logic [3:0]      tog_cnt;
    logic [BCW-1:0]  byte_cnt;
    logic            miso_s1, miso_s2;
    logic            accept, tick, byte_end, more_bytes, shifting;
    logic [DIVW-1:0] div_sel;

    assign shifting   = (state == SHIFT);
    assign div_sel    = fast_r ? DIVW'(DIV_FAST) : DIVW'(DIV_SLOW);
    assign byte_end   = shifting && tick && (tog_cnt == 4'd15);
    assign more_bytes = (cmd_r == CMD_INIT) && (byte_cnt != '0);

    sd_spi_div #(.DIVW(DIVW)) u_div (
        .clock (clock),
        .reset (reset),
        .en    (shifting),
        .div   (div_sel),
        .tick  (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        ready   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    accept  = 1'b1;
                    state_n = (cmd == CMD_XFER || cmd == CMD_INIT) ? SHIFT : FIN;
                end
            end
            SHIFT:   if (byte_end && !more_bytes) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
            done     <= 1'b0;
            dout     <= 8'h00;
            sd_clk   <= 1'b0;
            sd_mosi  <= 1'b1;
            sd_cs    <= 1'b1;
            cmd_r    <= CMD_XFER;
            fast_r   <= 1'b0;
            shreg    <= 8'h00;
            tog_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            miso_s1 <= sd_miso;
            miso_s2 <= miso_s1;
            // Registered strobe lands in the first IDLE cycle, so done and ready coincide.
            done    <= (state == FIN);
            if (accept) begin
                cmd_r   <= cmd_e'(cmd);
                fast_r  <= fast;
                tog_cnt <= '0;
                sd_clk  <= 1'b0;
                case (cmd_e'(cmd))
                    CMD_XFER: begin
                        shreg   <= din;
                        sd_mosi <= din[7];
                    end
                    CMD_CS_ON:  sd_cs <= 1'b0;
                    CMD_CS_OFF: sd_cs <= 1'b1;
                    default: begin
                        sd_cs    <= 1'b1;
                        shreg    <= 8'hFF;
                        sd_mosi  <= 1'b1;
                        byte_cnt <= BCW'(INIT_BYTES - 1);
                    end
                endcase
            end else if (shifting && tick) begin
                sd_clk  <= ~sd_clk;
                tog_cnt <= tog_cnt + 4'd1;
                if (sd_clk) begin
                    // Falling toggle: capture MISO, present the next MOSI bit.
                    shreg   <= {shreg[6:0], miso_s2};
                    sd_mosi <= shreg[6];
                    if (tog_cnt == 4'd15) begin
                        sd_mosi <= 1'b1;
                        if (more_bytes) begin
                            byte_cnt <= byte_cnt - BCW'(1);
                            shreg    <= 8'hFF;
                        end else begin
                            dout <= {shreg[6:0], miso_s2};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboarded bench for sd_spi_master: directed commands, MISO card model, edge monitor.
module tb_sd_spi_master;
    import sd_spi_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] cmd   = 2'b00;
    logic       fast  = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       valid = 1'b0;
    logic       valid0 = 1'b0;
    logic       ready, done, sd_clk, sd_mosi, sd_cs, sd_miso;
    logic [7:0] dout;
    logic       ready0, done0, sd_clk0, sd_mosi0, sd_cs0;
    logic [7:0] dout0;

    int          pcnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          falls = 0;
    int          fall_base = 0;
    logic [15:0] miso_pat = 16'hFFFF;
    bit          stop = 1'b0;

    typedef struct { logic [7:0] dout; int cyc; } exp_t;
    exp_t sb[$];
    int   rise_at[$];
    logic mosi_at[$];
    logic cs_at[$];

    sd_spi_master dut (
        .clock(clock), .reset(reset), .cmd(cmd), .fast(fast), .din(din),
        .valid(valid), .ready(ready), .done(done), .dout(dout),
        .sd_clk(sd_clk), .sd_mosi(sd_mosi), .sd_cs(sd_cs), .sd_miso(sd_miso)
    );

    sd_spi_master #(.DIV_FAST(0)) dut0 (
        .clock(clock), .reset(reset), .cmd(cmd), .fast(fast), .din(din),
        .valid(valid0), .ready(ready0), .done(done0), .dout(dout0),
        .sd_clk(sd_clk0), .sd_mosi(sd_mosi0), .sd_cs(sd_cs0), .sd_miso(1'b0)
    );

    always #5 clock = ~clock;
    always @(posedge clock) pcnt <= pcnt + 1;

    // Card model: next MISO bit appears after each falling sd_clk, first bit before the byte.
    always_comb begin
        int idx;
        idx = falls - fall_base;
        sd_miso = (idx >= 0 && idx < 16) ? miso_pat[15 - idx] : 1'b1;
    end

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic issue(input logic [1:0] c, input logic f, input logic [7:0] d,
                         input bit push, input logic [7:0] ed, input int lat, output int acc);
        int w;
        w = 0;
        @(negedge clock);
        while (!ready && w < 300) begin
            @(negedge clock);
            w++;
        end
        if (!ready) chk("issue_ready_timeout", 0, 1);
        cmd = c; fast = f; din = d; valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        acc   = pcnt;
        valid = 1'b0;
        if (push) sb.push_back('{ed, acc + lat});
    endtask

    task automatic wait_idle(input int maxc);
        int w;
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while ((sb.size() != 0 || !ready) && w < maxc);
        if (w >= maxc) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        fork
            begin : stim
                int e, e2, base, nr, nz, bad, first, last, donec;
                logic [7:0]  bits, dsave;
                logic [15:0] bits16;
                logic        prevc;

                @(negedge clock);
                chk("rst_sd_clk", sd_clk, 0);
                chk("rst_sd_mosi", sd_mosi, 1);
                chk("rst_sd_cs", sd_cs, 1);
                chk("rst_ready", ready, 1);
                chk("rst_done", done, 0);
                chk("rst_dout", dout, 8'h00);
                reset = 1'b0;

                issue(CMD_CS_ON, 1'b1, 8'h00, 1'b1, 8'h00, 1, e);
                chk("cs_on_edge", sd_cs, 0);
                chk("cs_on_no_early_done", done, 0);
                wait_idle(50);

                // XFER A5 fast, card returns 3C
                miso_pat = 16'h3CFF; fall_base = falls; base = rise_at.size();
                issue(CMD_XFER, 1'b1, 8'hA5, 1'b1, 8'h3C, 33, e);
                wait_idle(200);
                chk("a5_rises", rise_at.size() - base, 8);
                if (rise_at.size() >= base + 8) begin
                    bits = '0; nr = 0;
                    for (int j = 0; j < 8; j++) begin
                        bits = {bits[6:0], mosi_at[base + j]};
                        nr += int'(cs_at[base + j]);
                    end
                    chk("a5_mosi_bits", bits, 8'hA5);
                    chk("a5_cs_high_rises", nr, 0);
                    chk("a5_first_rise", rise_at[base], e + 2);
                    chk("a5_last_rise", rise_at[base + 7], e + 30);
                end

                // valid held through a byte with changed cmd/din, re-accept in done cycle
                miso_pat = 16'hC396; fall_base = falls; base = rise_at.size();
                @(negedge clock);
                cmd = CMD_XFER; fast = 1'b1; din = 8'h5A; valid = 1'b1;
                @(posedge clock);
                @(negedge clock);
                e = pcnt;
                sb.push_back('{8'hC3, e + 33});
                cmd = CMD_CS_OFF; din = 8'h00;
                nr = 0;
                while (!ready && nr < 100) begin
                    @(negedge clock);
                    nr++;
                end
                chk("b2b_ready_cycle", pcnt, e + 33);
                cmd = CMD_XFER; din = 8'h81;
                @(posedge clock);
                @(negedge clock);
                e2 = pcnt; valid = 1'b0;
                sb.push_back('{8'h96, e2 + 33});
                chk("b2b_reaccept", e2, e + 34);
                wait_idle(200);
                chk("b2b_rises", rise_at.size() - base, 16);
                if (rise_at.size() >= base + 16) begin
                    bits16 = '0; nr = 0;
                    for (int j = 0; j < 16; j++) begin
                        bits16 = {bits16[14:0], mosi_at[base + j]};
                        nr += int'(cs_at[base + j]);
                    end
                    chk("b2b_mosi_bits", bits16, 16'h5A81);
                    chk("b2b_cs_held_low", nr, 0);
                    chk("b2b_second_first_rise", rise_at[base + 8], e + 36);
                end

                // CS_OFF then XFER: sd_cs stays high
                issue(CMD_CS_OFF, 1'b1, 8'h00, 1'b1, 8'h96, 1, e);
                wait_idle(50);
                chk("cs_off_level", sd_cs, 1);
                miso_pat = 16'h69FF; fall_base = falls; base = rise_at.size();
                issue(CMD_XFER, 1'b1, 8'h3C, 1'b1, 8'h69, 33, e);
                wait_idle(200);
                nz = 0;
                for (int j = base; j < rise_at.size(); j++) nz += int'(!cs_at[j]);
                chk("csoff_xfer_rises", rise_at.size() - base, 8);
                chk("csoff_xfer_cs_low_rises", nz, 0);

                // INIT slow: 80 clocks, CS and MOSI high, period 126
                miso_pat = 16'hFFFF; fall_base = falls; base = rise_at.size();
                issue(CMD_INIT, 1'b0, 8'h00, 1'b1, 8'hFF, 10081, e);
                wait_idle(11000);
                nz = 0; nr = 0; bad = 0;
                for (int j = base; j < rise_at.size(); j++) begin
                    nz += int'(!mosi_at[j]);
                    nr += int'(!cs_at[j]);
                    if (j > base && rise_at[j] - rise_at[j - 1] != 126) bad++;
                end
                chk("init_rises", rise_at.size() - base, 80);
                chk("init_mosi_low_rises", nz, 0);
                chk("init_cs_low_rises", nr, 0);
                chk("init_bad_periods", bad, 0);
                if (rise_at.size() > base) chk("init_first_rise", rise_at[base], e + 63);

                // DIV_FAST=0 build: 25 MHz, MISO tied low
                @(negedge clock);
                chk("f0_ready", ready0, 1);
                cmd = CMD_XFER; din = 8'hFF; fast = 1'b1; valid0 = 1'b1;
                @(posedge clock);
                @(negedge clock);
                e = pcnt; valid0 = 1'b0;
                prevc = sd_clk0; nr = 0; first = -1; last = 0; bad = 0; nz = 0;
                donec = -1; dsave = 8'hAA;
                for (int k = 0; k < 30; k++) begin
                    @(negedge clock);
                    if (sd_clk0 && !prevc) begin
                        if (nr == 0) first = pcnt;
                        else if (pcnt - last != 2) bad++;
                        last = pcnt;
                        nr++;
                        nz += int'(!sd_mosi0);
                    end
                    prevc = sd_clk0;
                    if (done0) begin
                        donec = pcnt;
                        dsave = dout0;
                    end
                end
                chk("f0_rises", nr, 8);
                chk("f0_first_rise", first, e + 1);
                chk("f0_bad_periods", bad, 0);
                chk("f0_mosi_low_rises", nz, 0);
                chk("f0_done_cycle", donec, e + 17);
                chk("f0_dout", dsave, 8'h00);

                // Async reset in the middle of a byte
                issue(CMD_CS_ON, 1'b1, 8'h00, 1'b1, 8'hFF, 1, e);
                wait_idle(50);
                issue(CMD_XFER, 1'b1, 8'hA5, 1'b0, 8'h00, 0, e);
                repeat (10) @(negedge clock);
                chk("midrst_pre_sd_clk", sd_clk, 1);
                reset = 1'b1;
                #1;
                chk("midrst_sd_cs", sd_cs, 1);
                chk("midrst_sd_clk", sd_clk, 0);
                chk("midrst_sd_mosi", sd_mosi, 1);
                chk("midrst_ready", ready, 1);
                chk("midrst_dout", dout, 8'h00);
                chk("midrst_done", done, 0);
                repeat (3) @(negedge clock);
                reset = 1'b0;
                repeat (40) @(negedge clock);
                stop = 1'b1;
            end
            begin : mon
                logic prev;
                exp_t ex;
                prev = 1'b0;
                while (!stop) begin
                    @(negedge clock);
                    if (sd_clk && !prev) begin
                        rise_at.push_back(pcnt);
                        mosi_at.push_back(sd_mosi);
                        cs_at.push_back(sd_cs);
                    end
                    if (!sd_clk && prev) falls++;
                    prev = sd_clk;
                    if (done) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            ex = sb.pop_front();
                            chk("sb_dout", dout, ex.dout);
                            chk("sb_done_cycle", pcnt, ex.cyc);
                        end
                    end
                end
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
